rr_arb8: RTL and testbench
==========================

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter MAX_HOLD, default 16, meaning maximum consecutive cycles a grant may be held before forced revoke; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enb  input  1  arbiter enable; low blocks new grants and revokes any active grant.
REQ-005 req  input  8  request vector; bit k high = requester k wants the shared resource, held high for the whole use.
REQ-006 gnt  output  8  registered one-hot grant vector; all-zero when no grant.
REQ-007 gnt_idx  output  3  registered binary index of granted requester; 3'b000 when gnt_vld low.
REQ-008 gnt_vld  output  1  registered, high while any gnt bit is high.
REQ-009 tmo  output  1  registered one-cycle pulse marking a forced revoke by hold timeout.

Function
REQ-010 FSM states SHALL be IDLE, GRANT, GAP; reset state IDLE.
REQ-011 IDLE: if enb=1 and req!=0, SHALL select winner by round-robin from ptr+1 upward, modulo 8, and enter GRANT; otherwise stay IDLE.
REQ-012 ptr SHALL be a 3-bit register holding last granted index; reset value 3'd7 so requester 0 has first priority.
REQ-013 Grant latency SHALL be exactly one cycle: req sampled in IDLE at edge t, gnt/gnt_idx/gnt_vld valid after edge t+1.
REQ-014 On entering GRANT, ptr SHALL load the winner index and hold counter hcnt SHALL load 1.
REQ-015 gnt SHALL be one-hot of the winner and gnt_idx its binary encoding, stable for the whole GRANT state.
REQ-016 GRANT: if req[gnt_idx]=0, SHALL go to GAP (normal release).
REQ-017 GRANT: else if hcnt=MAX_HOLD, SHALL go to GAP and assert tmo for exactly one cycle (coinciding with first GAP cycle).
REQ-018 GRANT: else if enb=0, SHALL go directly to IDLE without tmo.
REQ-019 GRANT: otherwise hcnt SHALL increment by 1; hcnt width 8 bits, never wraps since MAX_HOLD<=255.
REQ-020 Priority of GRANT exits SHALL be release > timeout > enb low when simultaneous.
REQ-021 GAP SHALL last exactly one cycle with gnt=0, gnt_vld=0, gnt_idx=0, then go to IDLE; requests during GAP are ignored.
REQ-022 Release-to-next-grant turnaround SHALL be 3 cycles (GRANT->GAP->IDLE->GRANT).
REQ-023 Winner selection SHALL use only the current req vector; no request queuing or memory of dropped requests.
REQ-024 A requester revoked by timeout SHALL be lowest priority in the next arbitration (ptr equals its index).
REQ-025 Outputs in IDLE SHALL be gnt=0, gnt_idx=0, gnt_vld=0, tmo=0.
REQ-026 Glitch-free: all outputs SHALL be driven from registers only.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, ptr=7, hcnt=0, gnt=0, gnt_idx=0, gnt_vld=0, tmo=0, independent of clk.
REQ-028 Reset asserted mid-GRANT SHALL drop gnt asynchronously; first arbitration after rst_n release starts from requester 0.
REQ-029 No grant SHALL be issued on the first rising edge coincident with rst_n deassertion if recovery timing is violated; bench holds rst_n low >=2 cycles.

Verification
REQ-030 Reset, enb=1, req=8'h01 -> after 1 edge gnt=8'h01, gnt_idx=0, gnt_vld=1.
REQ-031 req=8'hFF held, each owner drops own bit for one cycle after 3 cycles -> grant order 0,1,2,...,7,0 with 3-cycle turnaround.
REQ-032 MAX_HOLD=4, req=8'h24 held constant -> gnt 8'h04 for 4 cycles, tmo pulse, GAP, then gnt=8'h20 (idx 5).
REQ-033 Owner 3 granted, enb driven low -> next edge gnt=0, tmo=0, state IDLE; no grant while enb=0 and req=8'h08.
REQ-034 rst_n pulled low asynchronously mid-grant of idx 6 -> gnt=0 before next edge; after release with req=8'h41 grant goes to idx 0.
REQ-035 Release and timeout same cycle (req drop at hcnt=MAX_HOLD) -> GAP entered, tmo stays 0.

Source files
------------

// File: rtl/rr_arb8.sv
// ============================================================================
// rr_arb8 : 8-way round-robin arbiter with hold timeout and one-cycle gap
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_arb8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enb,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       tmo
);

  localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hcnt;

  logic [2:0] w_win_idx;
  logic [2:0] w_cand;

  // Scan from farthest to nearest so the requester right after ptr wins last.
  always_comb begin
    w_win_idx = 3'd0;
    w_cand    = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      w_cand = r_ptr + 3'(i);
      if (req[w_cand]) begin
        w_win_idx = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd7;
      r_hcnt  <= 8'd0;
      gnt     <= 8'h00;
      gnt_idx <= 3'd0;
      gnt_vld <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      tmo <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enb && (req != 8'h00)) begin
            r_state <= S_GRANT;
            r_ptr   <= w_win_idx;
            r_hcnt  <= 8'd1;
            gnt     <= 8'b1 << w_win_idx;
            gnt_idx <= w_win_idx;
            gnt_vld <= 1'b1;
          end
        end
        S_GRANT: begin
          // Exit priority: release, then timeout, then enable drop.
          if (!req[gnt_idx]) begin
            r_state <= S_GAP;
            gnt     <= 8'h00;
            gnt_idx <= 3'd0;
            gnt_vld <= 1'b0;
          end else if (r_hcnt == c_max_hold) begin
            r_state <= S_GAP;
            tmo     <= 1'b1;
            gnt     <= 8'h00;
            gnt_idx <= 3'd0;
            gnt_vld <= 1'b0;
          end else if (!enb) begin
            r_state <= S_IDLE;
            gnt     <= 8'h00;
            gnt_idx <= 3'd0;
            gnt_vld <= 1'b0;
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          gnt     <= 8'h00;
          gnt_idx <= 3'd0;
          gnt_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arb8.sv
// ============================================================================
// tb_rr_arb8 : vector table, directed corner sequences and random traffic
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rr_arb8;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic       enb;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  rr_arb8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enb     (enb),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: who owns the resource, for how long, and whether a gap cycle is due.
  int m_owner;
  int m_held;
  int m_last;
  bit m_gap;
  bit m_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 7;
    m_gap   = 1'b0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step();
    bit found;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_tmo = 1'b0;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
        m_gap   = 1'b1;
      end else if (m_held == MAX_HOLD) begin
        m_owner = -1;
        m_gap   = 1'b1;
        m_tmo   = 1'b1;
      end else if (!enb) begin
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (enb && req != 8'h00) begin
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        if (!found && req[(m_last + k) % 8]) begin
          m_owner = (m_last + k) % 8;
          found   = 1'b1;
        end
      end
      m_last = m_owner;
      m_held = 1;
    end
  endtask

  task automatic model_check();
    logic [7:0] e_gnt;
    e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk("model_gnt", gnt, e_gnt);
    chk("model_idx", gnt_idx, (m_owner >= 0) ? m_owner : 0);
    chk("model_vld", gnt_vld, m_owner >= 0);
    chk("model_tmo", tmo, m_tmo);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enb   = 1'b1;
    req   = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_idx", gnt_idx, 3'd0);
    chk("rst_vld", gnt_vld, 1'b0);
    chk("rst_tmo", tmo, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       enb;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       tmo;
  } vec_t;

  vec_t tbl[22];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    enb      = 1'b0;
    req      = 8'h00;
    model_reset();

    // {enb, req} applied before an edge, {gnt, idx, vld, tmo} expected after it
    tbl[0]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h02, 8'h02, 3'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h06, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'h04, 8'h00, 3'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 8'h04, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

    do_reset();
    for (int v = 0; v < 22; v++) begin
      enb = tbl[v].enb;
      req = tbl[v].req;
      tick();
      chk($sformatf("tbl%0d_gnt", v), gnt, tbl[v].gnt);
      chk($sformatf("tbl%0d_idx", v), gnt_idx, tbl[v].idx);
      chk($sformatf("tbl%0d_vld", v), gnt_vld, tbl[v].vld);
      chk($sformatf("tbl%0d_tmo", v), tmo, tbl[v].tmo);
    end

    // Full rotation with every owner releasing after three cycles of use.
    do_reset();
    req = 8'hFF;
    tick();
    for (int n = 0; n < 9; n++) begin
      chk("rr_idx", gnt_idx, n % 8);
      chk("rr_vld", gnt_vld, 1'b1);
      tick();
      tick();
      req = 8'hFF & ~(8'h01 << (n % 8));
      tick();
      chk("rr_gap", gnt_vld, 1'b0);
      req = 8'hFF;
      tick();
      chk("rr_idle", gnt_vld, 1'b0);
      tick();
    end

    // Timeout hands over to the next requester, owner becomes lowest priority.
    do_reset();
    req = 8'h24;
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      chk("to_hold", gnt, 8'h04);
    end
    tick();
    chk("to_tmo", tmo, 1'b1);
    chk("to_gap", gnt, 8'h00);
    tick();
    chk("to_tmo_clr", tmo, 1'b0);
    tick();
    chk("to_next", gnt, 8'h20);
    chk("to_next_idx", gnt_idx, 3'd5);

    // Enable drop revokes immediately without a timeout pulse.
    do_reset();
    req = 8'h08;
    tick();
    chk("en_gnt", gnt, 8'h08);
    enb = 1'b0;
    tick();
    chk("en_drop", gnt, 8'h00);
    chk("en_tmo", tmo, 1'b0);
    repeat (3) begin
      tick();
      chk("en_block", gnt_vld, 1'b0);
    end
    enb = 1'b1;

    // Asynchronous reset mid-grant, then first arbitration restarts at 0.
    do_reset();
    req = 8'h40;
    tick();
    chk("ar_gnt", gnt, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_gnt", gnt, 8'h00);
    chk("ar_async_vld", gnt_vld, 1'b0);
    model_reset();
    req = 8'h41;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_restart", gnt, 8'h01);
    chk("ar_restart_idx", gnt_idx, 3'd0);

    // Random traffic against the model.
    do_reset();
    for (int r = 0; r < 800; r++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 7) == 0) req = 8'h00;
      enb = ($urandom_range(0, 11) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
